// File: rtl/ram_port_arbiter_if.sv
// Bundle of the two requester command/response channels and RAM port A for ram_port_arbiter.
// The slave modport is the arbiter's view; master is the requester/RAM environment's view.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              r0_valid;
    logic              r0_write;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ready;
    logic              r0_rsp_valid;
    logic [DATA_W-1:0] r0_rsp_data;

    logic              r1_valid;
    logic              r1_write;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ready;
    logic              r1_rsp_valid;
    logic [DATA_W-1:0] r1_rsp_data;

    logic              a_en;
    logic              a_write_en;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;

    modport slave (
        input  r0_valid, r0_write, r0_addr, r0_wdata,
        input  r1_valid, r1_write, r1_addr, r1_wdata,
        input  a_rdata,
        output r0_ready, r0_rsp_valid, r0_rsp_data,
        output r1_ready, r1_rsp_valid, r1_rsp_data,
        output a_en, a_write_en, a_addr, a_wdata
    );

    modport master (
        output r0_valid, r0_write, r0_addr, r0_wdata,
        output r1_valid, r1_write, r1_addr, r1_wdata,
        output a_rdata,
        input  r0_ready, r0_rsp_valid, r0_rsp_data,
        input  r1_ready, r1_rsp_valid, r1_rsp_data,
        input  a_en, a_write_en, a_addr, a_wdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer for RAM port A with a registered issue stage and read-response routing.
// Build option: define RAM_PORT_ARB_ROUND_ROBIN_EN for round-robin grant; default is fixed priority with r1 starvation guard.
module ram_port_arbiter #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_port_arbiter_if.slave     bus
);

    typedef enum logic {
        OWNER_R0 = 1'b0,
        OWNER_R1 = 1'b1
    } owner_t;

    logic              grant0;
    logic              grant1;
    logic              accept;

    logic              issue_en;
    logic              issue_write;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] issue_wdata;
    owner_t            issue_owner;

    logic              rsp_pending;
    owner_t            rsp_owner;

`ifdef RAM_PORT_ARB_ROUND_ROBIN_EN
    owner_t last_grant;

    // Contended cycles go to whichever requester did not win most recently.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.r0_valid && (!bus.r1_valid || last_grant == OWNER_R1)) begin
                grant0 = 1'b1;
            end else if (bus.r1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant <= OWNER_R1;
        end else if (grant0) begin
            last_grant <= OWNER_R0;
        end else if (grant1) begin
            last_grant <= OWNER_R1;
        end
    end
`else
    localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt;
    logic             starved;

    assign starved = (starve_cnt == LIMIT);

    // r0 normally wins; a starved r1 takes the port for one cycle.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.r1_valid && (starved || !bus.r0_valid)) begin
                grant1 = 1'b1;
            end else if (bus.r0_valid) begin
                grant0 = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant1) begin
            starve_cnt <= '0;
        end else if (bus.r1_valid && !starved) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    assign accept       = grant0 | grant1;
    assign bus.r0_ready = grant0;
    assign bus.r1_ready = grant1;

    // Command fields hold when idle so the RAM pins only toggle on real accesses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_en    <= 1'b0;
            issue_write <= 1'b0;
            issue_addr  <= '0;
            issue_wdata <= '0;
            issue_owner <= OWNER_R0;
        end else begin
            issue_en <= accept;
            if (accept) begin
                issue_write <= grant1 ? bus.r1_write : bus.r0_write;
                issue_addr  <= grant1 ? bus.r1_addr  : bus.r0_addr;
                issue_wdata <= grant1 ? bus.r1_wdata : bus.r0_wdata;
                issue_owner <= grant1 ? OWNER_R1 : OWNER_R0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_pending <= 1'b0;
            rsp_owner   <= OWNER_R0;
        end else begin
            rsp_pending <= issue_en && !issue_write;
            rsp_owner   <= issue_owner;
        end
    end

    assign bus.a_en       = issue_en;
    assign bus.a_write_en = issue_write;
    assign bus.a_addr     = issue_addr;
    assign bus.a_wdata    = issue_wdata;

    assign bus.r0_rsp_valid = rsp_pending && (rsp_owner == OWNER_R0);
    assign bus.r1_rsp_valid = rsp_pending && (rsp_owner == OWNER_R1);
    assign bus.r0_rsp_data  = bus.r0_rsp_valid ? bus.a_rdata : '0;
    assign bus.r1_rsp_data  = bus.r1_rsp_valid ? bus.a_rdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized bench for ram_port_arbiter with a RAM model and a transaction-level reference model.
module tb_ram_port_arbiter;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 8;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct {
        int               due;
        bit               owner;
        logic [DATA_W-1:0] data;
    } rsp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    ram_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    // Block RAM port A: one-cycle registered read, no reset on contents.
    logic [DATA_W-1:0] ram [1024];
    logic [DATA_W-1:0] rdata_q;
    always @(posedge clock) begin
        if (bus.a_en) begin
            if (bus.a_write_en) ram[bus.a_addr] <= bus.a_wdata;
            else                rdata_q <= ram[bus.a_addr];
        end
    end
    assign bus.a_rdata = rdata_q;

    // Reference model state: committed memory image in program order plus expected responses.
    logic [DATA_W-1:0] shadow [1024];
    rsp_t              rspq [$];
    int                total = 0;
    int                bad   = 0;
    int                cyc   = 0;
    bit                last_r1  = 1'b1;
    int                wait_cnt = 0;
    logic              exp_en = 1'b0, exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] exp_wdata = '0;
    cmd_t              cmd0 = '0, cmd1 = '0;
    bit                granted0 = 1'b0, granted1 = 1'b0;
    logic              seen_rsp0_valid, seen_rsp1_valid;
    logic [DATA_W-1:0] seen_rsp0_data;
    logic [ADDR_W-1:0] addr_set [8] = '{10'h3FF, 10'h000, 10'h010, 10'h020, 10'h155, 10'h2AA, 10'h001, 10'h3FE};
    logic [9:0]        g1_hist;
    logic [9:0]        g1_expect;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic void ref_grant(input cmd_t c0, input cmd_t c1, output bit e0, output bit e1);
        e0 = 1'b0;
        e1 = 1'b0;
`ifdef RAM_PORT_ARB_ROUND_ROBIN_EN
        if (c0.valid && c1.valid) begin
            if (last_r1) e0 = 1'b1;
            else         e1 = 1'b1;
        end else begin
            e0 = c0.valid;
            e1 = c1.valid;
        end
`else
        if (c1.valid && (!c0.valid || wait_cnt >= STARVE_LIMIT)) e1 = 1'b1;
        else                                                    e0 = c0.valid;
`endif
    endfunction

    task automatic drive_inputs();
        bus.r0_valid = cmd0.valid; bus.r0_write = cmd0.write; bus.r0_addr = cmd0.addr; bus.r0_wdata = cmd0.wdata;
        bus.r1_valid = cmd1.valid; bus.r1_write = cmd1.write; bus.r1_addr = cmd1.addr; bus.r1_wdata = cmd1.wdata;
    endtask

    // One clock: check every output mid-cycle, then advance the model across the edge.
    task automatic step_cycle();
        bit                e0, e1, ev0, ev1;
        logic [DATA_W-1:0] ed0, ed1;
        cmd_t              c;
        #4;
        ref_grant(cmd0, cmd1, e0, e1);
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
        if (rspq.size() > 0 && rspq[0].due == cyc) begin
            if (rspq[0].owner) begin ev1 = 1'b1; ed1 = rspq[0].data; end
            else               begin ev0 = 1'b1; ed0 = rspq[0].data; end
            rspq.delete(0);
        end
        checkOutput("r0_ready", bus.r0_ready, e0);
        checkOutput("r1_ready", bus.r1_ready, e1);
        checkOutput("a_en", bus.a_en, exp_en);
        checkOutput("a_write_en", bus.a_write_en, exp_we);
        checkOutput("a_addr", bus.a_addr, exp_addr);
        checkOutput("a_wdata", bus.a_wdata, exp_wdata);
        checkOutput("r0_rsp_valid", bus.r0_rsp_valid, ev0);
        checkOutput("r1_rsp_valid", bus.r1_rsp_valid, ev1);
        checkOutput("r0_rsp_data", bus.r0_rsp_data, ed0);
        checkOutput("r1_rsp_data", bus.r1_rsp_data, ed1);
        seen_rsp0_valid = bus.r0_rsp_valid;
        seen_rsp1_valid = bus.r1_rsp_valid;
        seen_rsp0_data  = bus.r0_rsp_data;
        @(posedge clock);
        exp_en = e0 | e1;
        if (exp_en) begin
            c = e1 ? cmd1 : cmd0;
            exp_we    = c.write;
            exp_addr  = c.addr;
            exp_wdata = c.wdata;
            if (c.write) shadow[c.addr] = c.wdata;
            else         rspq.push_back('{due: cyc + 2, owner: e1, data: shadow[c.addr]});
        end
`ifdef RAM_PORT_ARB_ROUND_ROBIN_EN
        if (e0)      last_r1 = 1'b0;
        else if (e1) last_r1 = 1'b1;
`else
        if (e1)                                        wait_cnt = 0;
        else if (cmd1.valid && wait_cnt < STARVE_LIMIT) wait_cnt++;
`endif
        granted0 = e0;
        granted1 = e1;
        cyc++;
        #1;
    endtask

    task automatic applyStimulus(input cmd_t c0, input cmd_t c1);
        cmd0 = c0;
        cmd1 = c1;
        drive_inputs();
        step_cycle();
    endtask

    function automatic cmd_t mk(input bit v, input bit w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_t c;
        c.valid = v; c.write = w; c.addr = a; c.wdata = d;
        return c;
    endfunction

    // A requester left waiting must keep presenting the same command.
    function automatic cmd_t next_cmd(input cmd_t prev, input bit granted);
        if (prev.valid && !granted) return prev;
        return mk($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  addr_set[$urandom_range(0, 7)], DATA_W'($urandom));
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        cmd0 = mk(1'b1, 1'b0, 10'h010, 8'h00);
        cmd1 = mk(1'b1, 1'b1, 10'h020, 8'h5A);
        drive_inputs();
        #4;
        checkOutput("rst_r0_ready", bus.r0_ready, 1'b0);
        checkOutput("rst_r1_ready", bus.r1_ready, 1'b0);
        checkOutput("rst_a_en", bus.a_en, 1'b0);
        checkOutput("rst_a_write_en", bus.a_write_en, 1'b0);
        checkOutput("rst_a_addr", bus.a_addr, 0);
        checkOutput("rst_a_wdata", bus.a_wdata, 0);
        checkOutput("rst_r0_rsp_valid", bus.r0_rsp_valid, 1'b0);
        checkOutput("rst_r1_rsp_valid", bus.r1_rsp_valid, 1'b0);
        checkOutput("rst_r0_rsp_data", bus.r0_rsp_data, 0);
        checkOutput("rst_r1_rsp_data", bus.r1_rsp_data, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cmd0 = '0;
        cmd1 = '0;
        drive_inputs();
        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        rspq.delete();
        last_r1 = 1'b1;
        wait_cnt = 0;
        granted0 = 1'b0;
        granted1 = 1'b0;
    endtask

    initial begin
        drive_inputs();
        @(posedge clock);
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) applyStimulus(mk(1'b1, 1'b1, addr_set[i], DATA_W'($urandom)), '0);
            else            applyStimulus('0, mk(1'b1, 1'b1, addr_set[i], DATA_W'($urandom)));
        end
        applyStimulus('0, '0);
        applyStimulus('0, '0);

        applyStimulus(mk(1'b1, 1'b1, 10'h3FF, 8'hA5), '0);
        applyStimulus(mk(1'b1, 1'b0, 10'h3FF, 8'h00), '0);
        applyStimulus('0, '0);
        applyStimulus('0, '0);
        checkOutput("wr_rd_rsp_valid", seen_rsp0_valid, 1'b1);
        checkOutput("wr_rd_rsp_data", seen_rsp0_data, 8'hA5);
        checkOutput("wr_rd_r1_quiet", seen_rsp1_valid, 1'b0);

        applyStimulus(mk(1'b1, 1'b0, 10'h3FF, 8'h00), '0);
        applyStimulus(mk(1'b1, 1'b0, 10'h000, 8'h00), '0);
        for (int i = 0; i < 3; i++) applyStimulus('0, '0);

        do_reset();
        g1_hist = '0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(mk(1'b1, 1'b0, 10'h010, 8'h00), mk(1'b1, 1'b0, 10'h020, 8'h00));
            g1_hist[i] = granted1;
        end
`ifdef RAM_PORT_ARB_ROUND_ROBIN_EN
        g1_expect = 10'b1010101010;
`else
        g1_expect = 10'b1000010000;
`endif
        checkOutput("grant_pattern", {22'd0, g1_hist}, {22'd0, g1_expect});
        for (int i = 0; i < 3; i++) applyStimulus('0, '0);

        for (int i = 0; i < 300; i++) begin
            cmd_t n0, n1;
            n0 = next_cmd(cmd0, granted0);
            n1 = next_cmd(cmd1, granted1);
            applyStimulus(n0, n1);
        end
        for (int i = 0; i < 3; i++) applyStimulus('0, '0);

        applyStimulus('0, mk(1'b1, 1'b0, 10'h020, 8'h00));
        do_reset();
        for (int i = 0; i < 4; i++) applyStimulus('0, '0);
        checkOutput("rst_drop_rsp1", seen_rsp1_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
